// File: rtl/aes_spi_ctrl_if.sv
// Pin-side SPI signals plus the parallel start/done interface of the AES core.
interface aes_spi_ctrl_if #(
  parameter int NK = 4
);
  logic              cs_n;
  logic              sdi;
  logic              sdo;
  logic              aes_start;
  logic [127:0]      aes_pt;
  logic [32*NK-1:0]  aes_key;
  logic              aes_done;
  logic [127:0]      aes_ct;
  logic              busy;
  logic              abort;
  logic              timeout;

  modport slave (
    input  cs_n, sdi, aes_done, aes_ct,
    output sdo, aes_start, aes_pt, aes_key, busy, abort, timeout
  );

  modport master (
    output cs_n, sdi, aes_done, aes_ct,
    input  sdo, aes_start, aes_pt, aes_key, busy, abort, timeout
  );
endinterface

// File: rtl/aes_spi_ctrl.sv
// SPI front-end for the AES core: shifts in plaintext+key, pulses start, waits for done, shifts ct out.
// aes_start follows the last key bit by one cycle; ct MSB is on sdo the cycle after aes_done; cs_n high aborts.
module aes_spi_ctrl #(
  parameter int NK        = 4,
  parameter int TO_CYCLES = 1024
) (
  input logic           clk,
  input logic           rst,
  aes_spi_ctrl_if.slave bus
);
  localparam int KW      = 32 * NK;
  localparam int RX_BITS = 128 + KW;
  localparam int RW      = RX_BITS - 1;
  localparam int WW      = $clog2(TO_CYCLES + 2);

  typedef enum logic [2:0] {IDLE, RX, START, WAIT, TX, DONE} state_t;

  state_t            state, state_nxt;
  logic [8:0]        cnt, cnt_nxt;
  logic [RW-1:0]     rx_shift, rx_nxt;
  logic [RX_BITS-1:0] rx_full;
  logic [127:0]      tx_shift, tx_nxt;
  logic [WW-1:0]     wcnt, wcnt_nxt;
  logic [127:0]      pt_q, pt_nxt;
  logic [KW-1:0]     key_q, key_nxt;
  logic              abort_q, abort_nxt;
  logic              to_q, to_nxt;

  // The final bit never lands in the shift register; it joins the frame on the load edge.
  assign rx_full = {rx_shift, bus.sdi};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      wcnt     <= '0;
      pt_q     <= '0;
      key_q    <= '0;
      abort_q  <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      rx_shift <= rx_nxt;
      tx_shift <= tx_nxt;
      wcnt     <= wcnt_nxt;
      pt_q     <= pt_nxt;
      key_q    <= key_nxt;
      abort_q  <= abort_nxt;
      to_q     <= to_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rx_nxt    = rx_shift;
    tx_nxt    = tx_shift;
    wcnt_nxt  = wcnt;
    pt_nxt    = pt_q;
    key_nxt   = key_q;
    abort_nxt = 1'b0;
    to_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.cs_n) begin
          rx_nxt    = {{(RW-1){1'b0}}, bus.sdi};
          cnt_nxt   = 9'd1;
          state_nxt = RX;
        end
      end
      RX: begin
        if (bus.cs_n) begin
          abort_nxt = 1'b1;
          state_nxt = IDLE;
        end else begin
          rx_nxt  = {rx_shift[RW-2:0], bus.sdi};
          cnt_nxt = cnt + 9'd1;
          if (cnt == 9'(RX_BITS - 1)) begin
            pt_nxt    = rx_full[RX_BITS-1 -: 128];
            key_nxt   = rx_full[KW-1:0];
            state_nxt = START;
          end
        end
      end
      START: begin
        // cs_n is not checked here; a late abort is taken from WAIT.
        wcnt_nxt  = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.cs_n) begin
          abort_nxt = 1'b1;
          state_nxt = IDLE;
        end else if (bus.aes_done) begin
          tx_nxt    = bus.aes_ct;
          cnt_nxt   = '0;
          state_nxt = TX;
        end else begin
          wcnt_nxt = wcnt + WW'(1);
          if (TO_CYCLES != 0 && wcnt == WW'(TO_CYCLES - 1)) begin
            to_nxt    = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      TX: begin
        if (bus.cs_n) begin
          abort_nxt = 1'b1;
          state_nxt = IDLE;
        end else begin
          tx_nxt  = {tx_shift[126:0], 1'b0};
          cnt_nxt = cnt + 9'd1;
          if (cnt == 9'd127) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (bus.cs_n) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.sdo       = (state == TX) ? tx_shift[127] : 1'b0;
  assign bus.aes_start = (state == START);
  assign bus.aes_pt    = pt_q;
  assign bus.aes_key   = key_q;
  assign bus.busy      = (state != IDLE);
  assign bus.abort     = abort_q;
  assign bus.timeout   = to_q;
endmodule
